// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: shared constants and helpers for the interrupt controller.
//   - Register word offsets (addr[4:2]) for PENDING, ENABLE, EDGE, RAW, POLARITY.
//   - MAX_NSRC: upper bound on the number of interrupt sources.
//   - lane_mask(): expands the 4-bit byte strobe into a 32-bit bit mask.
package irq_ctrl_pkg;

  localparam int MAX_NSRC = 16;

  localparam logic [2:0] OFF_PENDING  = 3'd0;  // 0x00
  localparam logic [2:0] OFF_ENABLE   = 3'd1;  // 0x04
  localparam logic [2:0] OFF_EDGE     = 3'd2;  // 0x08
  localparam logic [2:0] OFF_RAW      = 3'd3;  // 0x0C
  localparam logic [2:0] OFF_POLARITY = 3'd4;  // 0x10

  function automatic logic [31:0] lane_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/irq_sync.sv
// irq_sync: single-bit multi-flop synchronizer for an asynchronous pad input.
//   clk, resetn : clock, async active-low reset (flops clear to 0)
//   d           : asynchronous input
//   q           : synchronized output (last flop of the chain)
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff_r;

  // Shift the async input through the synchronizer chain.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ff_r <= {STAGES{1'b0}};
    end else begin
      ff_r <= {ff_r[STAGES-2:0], d};
    end
  end

  assign q = ff_r[STAGES-1];

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller with per-source edge/level mode.
//   clk, resetn   : clock, async active-low reset
//   valid/ready   : one-cycle bus handshake; ready pulses once per request
//   wstrb         : byte strobes, all zero = read
//   addr[4:2]     : register select (PENDING, ENABLE, EDGE, RAW, POLARITY)
//   wdata / rdata : write data / registered read data (0 when ready=0)
//   src           : asynchronous interrupt sources
//   irq           : irq[IRQ_BASE+i] = registered pending[i] & enable[i]
// Optional feature: define IRQ_CTRL_POLARITY_EN to add the POLARITY register
// at 0x10 (1 = source is active-low). Without it 0x10 reads 0.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NSRC        = 8,
  parameter int IRQ_BASE    = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             valid,
  output logic             ready,
  input  logic [3:0]       wstrb,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [NSRC-1:0]  src,
  output logic [31:0]      irq
);

  localparam logic [NSRC-1:0] ZERO_N = {NSRC{1'b0}};

  logic [NSRC-1:0] sync_s, act_s, pol_cur_s, pol_nxt_s;
  logic [NSRC-1:0] hist_r, pending_r, enable_r, edge_r;
  logic [NSRC-1:0] pending_nxt_s, enable_nxt_s, edge_nxt_s;
  logic [NSRC-1:0] w1c_s, rise_s, mode_chg_s, wmask_s, wdat_s;
  logic [31:0]     mask32_s, rd_mux_s, irq_nxt_s, rdata_r, irq_r;
  logic [2:0]      reg_sel_s;
  logic            accept_s, wr_s, ready_r;

  for (genvar i = 0; i < NSRC; i++) begin : g_sync
    irq_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .resetn (resetn),
      .d      (src[i]),
      .q      (sync_s[i])
    );
  end

  // Bus decode: a request is taken only when no completion is in flight.
  always_comb begin
    accept_s  = valid & ~ready_r;
    wr_s      = accept_s & (wstrb != 4'd0);
    reg_sel_s = addr[4:2];
    mask32_s  = lane_mask(wstrb);
    wmask_s   = mask32_s[NSRC-1:0];
    wdat_s    = wdata[NSRC-1:0];
  end

`ifdef IRQ_CTRL_POLARITY_EN
  logic [NSRC-1:0] pol_r;

  // Next POLARITY value from a byte-gated write.
  always_comb begin
    if (wr_s && (reg_sel_s == OFF_POLARITY)) begin
      pol_nxt_s = (pol_r & ~wmask_s) | (wdat_s & wmask_s);
    end else begin
      pol_nxt_s = pol_r;
    end
  end

  // POLARITY register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pol_r <= ZERO_N;
    end else begin
      pol_r <= pol_nxt_s;
    end
  end

  assign pol_cur_s = pol_r;
`else
  assign pol_cur_s = ZERO_N;
  assign pol_nxt_s = ZERO_N;
`endif

  // Register write decode and pending next-state.
  always_comb begin
    if (wr_s && (reg_sel_s == OFF_PENDING)) begin
      w1c_s = wdat_s & wmask_s;
    end else begin
      w1c_s = ZERO_N;
    end
    if (wr_s && (reg_sel_s == OFF_ENABLE)) begin
      enable_nxt_s = (enable_r & ~wmask_s) | (wdat_s & wmask_s);
    end else begin
      enable_nxt_s = enable_r;
    end
    if (wr_s && (reg_sel_s == OFF_EDGE)) begin
      edge_nxt_s = (edge_r & ~wmask_s) | (wdat_s & wmask_s);
    end else begin
      edge_nxt_s = edge_r;
    end
    act_s      = sync_s ^ pol_cur_s;
    rise_s     = act_s & ~hist_r;
    // A mode or polarity change restarts the bit from a clean state.
    mode_chg_s = (edge_nxt_s ^ edge_r) | (pol_nxt_s ^ pol_cur_s);
    // Edge bits: set beats W1C. Level bits: follow the active source.
    pending_nxt_s = ((edge_r & (rise_s | (pending_r & ~w1c_s))) |
                     (~edge_r & act_s)) & ~mode_chg_s;
  end

  // Read mux; unimplemented bits and offsets read as zero.
  always_comb begin
    rd_mux_s = 32'd0;
    case (reg_sel_s)
      OFF_PENDING:  rd_mux_s[NSRC-1:0] = pending_r;
      OFF_ENABLE:   rd_mux_s[NSRC-1:0] = enable_r;
      OFF_EDGE:     rd_mux_s[NSRC-1:0] = edge_r;
      OFF_RAW:      rd_mux_s[NSRC-1:0] = sync_s;
`ifdef IRQ_CTRL_POLARITY_EN
      OFF_POLARITY: rd_mux_s[NSRC-1:0] = pol_r;
`endif
      default:      rd_mux_s = 32'd0;
    endcase
  end

  // Place the enabled pending bits at IRQ_BASE in the CPU vector.
  always_comb begin
    irq_nxt_s = 32'd0;
    irq_nxt_s[IRQ_BASE +: NSRC] = pending_r & enable_r;
  end

  // Register state, bus completion and outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hist_r    <= ZERO_N;
      pending_r <= ZERO_N;
      enable_r  <= ZERO_N;
      edge_r    <= ZERO_N;
      ready_r   <= 1'b0;
      rdata_r   <= 32'd0;
      irq_r     <= 32'd0;
    end else begin
      // History reloads with the post-write polarity so no false edge appears.
      hist_r    <= sync_s ^ pol_nxt_s;
      pending_r <= pending_nxt_s;
      enable_r  <= enable_nxt_s;
      edge_r    <= edge_nxt_s;
      ready_r   <= accept_s;
      if (accept_s) begin
        rdata_r <= rd_mux_s;
      end else begin
        rdata_r <= 32'd0;
      end
      irq_r     <= irq_nxt_s;
    end
  end

  assign ready = ready_r;
  assign rdata = rdata_r;
  assign irq   = irq_r;

  logic unused_s;
  assign unused_s = ^{addr[31:5], addr[1:0], wdata[31:NSRC], mask32_s[31:NSRC]};

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter NSRC, default 8: number of external interrupt sources, range 1..16.
REQ-002 Parameter IRQ_BASE, default 3: CPU irq bit driven by source 0; IRQ_BASE+NSRC SHALL be <= 32.
REQ-003 Parameter SYNC_STAGES, default 2: input synchronizer depth, range 2..3.
REQ-004 clk  input  1  single system clock; all state SHALL be on its rising edge.
REQ-005 resetn  input  1  reset, asynchronous assert, active-low.
REQ-006 valid  input  1  bus request, already qualified by the top-level address decode.
REQ-007 ready  output  1  bus completion strobe.
REQ-008 wstrb  input  4  byte write strobes; all zero means a read.
REQ-009 addr  input  32  byte address; only addr[4:2] is decoded.
REQ-010 wdata  input  32  write data.
REQ-011 rdata  output  32  read data, valid only while ready=1.
REQ-012 src  input  NSRC  asynchronous interrupt sources from pads.
REQ-013 irq  output  32  interrupt vector for the CPU irq input.

Function
REQ-014 Each src bit SHALL pass through SYNC_STAGES flops before any use; the last stage is sync[i].
REQ-015 Register map SHALL be: 0x00 PENDING (R, W1C), 0x04 ENABLE (RW), 0x08 EDGE (RW; 1=rising edge, 0=level), 0x0C RAW (R, sync value); other offsets SHALL read 0 and ignore writes.
REQ-016 Only bits [NSRC-1:0] SHALL be implemented; all other read bits SHALL be 0.
REQ-017 Bus: on valid=1 with ready=0, the block SHALL assert ready for exactly one cycle on the next clock. A write SHALL take effect on that same edge. ready SHALL stay 0 for the cycle after a completion even if valid is still 1.
REQ-018 rdata SHALL be registered with ready and SHALL be 0 when ready=0.
REQ-019 Byte lanes: each wstrb[k] SHALL gate bits [8k+7:8k] of the addressed register.
REQ-020 Edge mode: pending[i] SHALL set on the cycle after sync[i] goes 0 to 1, and SHALL clear only by a W1C write.
REQ-021 Level mode: pending[i] SHALL equal sync[i] delayed by one register; a W1C write SHALL have no lasting effect while sync[i]=1.
REQ-022 If a set and a W1C clear hit the same bit in the same cycle, set SHALL win.
REQ-023 pending SHALL update whether or not enable[i]=1. Enabling a bit that is already pending SHALL raise the irq.
REQ-024 irq[IRQ_BASE+i] SHALL be registered (pending[i] & enable[i]), giving 1 cycle of latency from pending to irq. All other irq bits SHALL be 0.
REQ-025 Changing EDGE[i] SHALL clear pending[i] in the same write cycle, and the edge history of bit i SHALL reload from sync[i], so no spurious edge is seen.

Reset
REQ-026 When resetn=0, the following SHALL clear asynchronously: synchronizer flops, edge history, PENDING, ENABLE, EDGE=0, ready=0, rdata=0, irq=0.
REQ-027 A transaction cut by reset SHALL be dropped. After reset deassertion there SHALL be no ready pulse until a new valid arrives.

Configuration
REQ-028 With macro IRQ_CTRL_POLARITY_EN defined: register 0x10 POLARITY (RW, reset 0) SHALL be present, with bit=1 inverting sync[i] before edge/level detection. Writing it SHALL clear pending[i] per REQ-025.
REQ-029 Without IRQ_CTRL_POLARITY_EN: offset 0x10 SHALL read 0 and ignore writes, and all sources SHALL be active-high.

Structure
REQ-030 A shared package SHALL hold the register offset constants (PENDING, ENABLE, EDGE, RAW, POLARITY) and the max-NSRC constant.
REQ-031 The per-bit synchronizer SHALL be a sub-module named irq_sync (parameter STAGES), instantiated NSRC times.

Verification
REQ-032 Reset with src=8'hFF, then release -> irq=0, PENDING reads 0, and no ready until first valid.
REQ-033 ENABLE=0x01, EDGE=0x01, pulse src[0] high for 1 cycle -> irq[3]=1 within SYNC_STAGES+2 cycles; write PENDING=0x01 -> irq[3]=0 the cycle after ready.
REQ-034 Level mode on src[2] held high, write PENDING=0x04 -> PENDING still reads 0x04; drop src[2] -> reads 0x00 within SYNC_STAGES+1 cycles.
REQ-035 Edge on src[1] coincident with a W1C of bit 1 -> PENDING reads 0x02 (set wins).
REQ-036 Back-to-back valid held 4 cycles -> ready pattern 0,1,0,1; write with wstrb=4'b0010 to ENABLE leaves bits [7:0] unchanged.
REQ-037 With IRQ_CTRL_POLARITY_EN: POLARITY=0x01, edge mode, src[0] falls 1 to 0 -> PENDING=0x01; without the macro, a read of 0x10 returns 0.
